// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter: op codes and direction encodings.
package barrel_shift_pkg;

  typedef enum logic [1:0] {
    OP_LSL_LSR = 2'b00,
    OP_ASR     = 2'b01,
    OP_ROT     = 2'b10,
    OP_PASS    = 2'b11
  } shift_op_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready bus for the pipelined barrel shifter: operand side and result side.
interface pipelined_barrel_shifter_if
  import barrel_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic             in_dir;
  shift_op_e        in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, in_data, in_amt, in_dir, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  // Shifter side.
  modport slave (
    input  in_valid, in_data, in_amt, in_dir, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );

endinterface

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One combinational shift step of STEP bit positions, enabled by one amount bit.
module shift_stage
  import barrel_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             sign,
  input  shift_op_e        op,
  input  logic             dir,
  input  logic             en,
  output logic [WIDTH-1:0] data_out
);

  // Select the shifted or unshifted word; sign is the original operand MSB.
  always_comb begin
    data_out = data_in;
    if (en && (op != OP_PASS)) begin
      if (dir == DIR_RIGHT) begin
        case (op)
          OP_ASR:  data_out = {{STEP{sign}}, data_in[WIDTH-1:STEP]};
          OP_ROT:  data_out = {data_in[STEP-1:0], data_in[WIDTH-1:STEP]};
          default: data_out = data_in >> STEP;
        endcase
      end else begin
        case (op)
          OP_ROT:  data_out = {data_in[WIDTH-STEP-1:0], data_in[WIDTH-1:WIDTH-STEP]};
          default: data_out = data_in << STEP;
        endcase
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shifter/rotator: one registered stage per amount bit, valid/ready on both ends.
module pipelined_barrel_shifter
  import barrel_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic                      clk,
  input logic                      rst,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  // Stage registers: data/valid for every stage, sideband only where a later stage reads it.
  logic [WIDTH-1:0] data_q [SHW];
  logic [SHW-1:0]   valid_q;
  shift_op_e        op_q   [SHW-1];
  logic [SHW-1:0]   amt_q  [SHW-1];
  logic [SHW-2:0]   dir_q;
  logic [SHW-2:0]   sign_q;

  // Per-stage combinational inputs and results.
  logic [WIDTH-1:0] stg_in   [SHW];
  logic [WIDTH-1:0] stg_out  [SHW];
  shift_op_e        stg_op   [SHW];
  logic [SHW-1:0]   stg_amt  [SHW];
  logic [SHW-1:0]   stg_dir;
  logic [SHW-1:0]   stg_sign;

  logic adv;

  assign adv          = bus.out_ready | ~valid_q[SHW-1];
  assign bus.in_ready = adv;
  assign bus.out_valid = valid_q[SHW-1];
  assign bus.out_data  = data_q[SHW-1];
  assign bus.out_zero  = (data_q[SHW-1] == '0);

  // Amount is shifted right one place per stage, so every stage consumes bit 0.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stg_in[k]   = bus.in_data;
      assign stg_op[k]   = bus.in_op;
      assign stg_amt[k]  = bus.in_amt;
      assign stg_dir[k]  = bus.in_dir;
      assign stg_sign[k] = bus.in_data[WIDTH-1];
    end else begin : g_rest
      assign stg_in[k]   = data_q[k-1];
      assign stg_op[k]   = op_q[k-1];
      assign stg_amt[k]  = amt_q[k-1];
      assign stg_dir[k]  = dir_q[k-1];
      assign stg_sign[k] = sign_q[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .STEP  (2 ** k)
    ) u_stage (
      .data_in  (stg_in[k]),
      .sign     (stg_sign[k]),
      .op       (stg_op[k]),
      .dir      (stg_dir[k]),
      .en       (stg_amt[k][0]),
      .data_out (stg_out[k])
    );
  end

  // Whole pipeline advances in lockstep when the output slot is free or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dir_q   <= '0;
      sign_q  <= '0;
      for (int unsigned i = 0; i < SHW; i++) begin
        data_q[i] <= '0;
      end
      for (int unsigned i = 0; i < SHW - 1; i++) begin
        op_q[i]  <= OP_LSL_LSR;
        amt_q[i] <= '0;
      end
    end else if (adv) begin
      valid_q <= {valid_q[SHW-2:0], bus.in_valid};
      dir_q   <= stg_dir[SHW-2:0];
      sign_q  <= stg_sign[SHW-2:0];
      for (int unsigned i = 0; i < SHW; i++) begin
        data_q[i] <= stg_out[i];
      end
      for (int unsigned i = 0; i < SHW - 1; i++) begin
        op_q[i]  <= stg_op[i];
        amt_q[i] <= stg_amt[i] >> 1;
      end
    end
  end

endmodule
